// File: rtl/uart_frame_pkg.sv
// Shared configuration for the burst UART: baud-rate select, parity mode and
// the receive oversampling factor.
package uart_frame_pkg;

    localparam int OVS = 16;

    typedef enum logic [1:0] {BR_9600, BR_19200, BR_57600, BR_115200} br;
    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} par_t;

    function automatic int br2hz(input br b);
        int hz;
        hz = 115200;
        case (b)
            BR_9600:   hz = 9600;
            BR_19200:  hz = 19200;
            BR_57600:  hz = 57600;
            BR_115200: hz = 115200;
            default:   hz = 115200;
        endcase
        return hz;
    endfunction

endpackage

// File: rtl/uart_frame_if.sv
// Register-side bus of the burst UART: configuration, TX burst handshake and
// RX burst results. The serial pins stay plain ports on the block.
interface uart_frame_if #(
    parameter int SZ = 4,
    parameter int DW = 8
);
    import uart_frame_pkg::*;

    br                    baud;
    par_t                 par;
    logic                 stop2;
    logic                 en_tx;
    logic [SZ-1:0][DW-1:0] tx_data;
    logic                 tx_busy;
    logic [SZ-1:0][DW-1:0] rx_data;
    logic                 rx_full;
    logic                 frame_err;
    logic                 par_err;

    modport master (
        output baud, par, stop2, en_tx, tx_data,
        input  tx_busy, rx_data, rx_full, frame_err, par_err
    );

    modport slave (
        input  baud, par, stop2, en_tx, tx_data,
        output tx_busy, rx_data, rx_full, frame_err, par_err
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Free-running 16x baud tick generator; the divider restarts whenever the
// selected rate changes so the first tick after a switch is a full period.
module uart_baud_gen
    import uart_frame_pkg::*;
#(
    parameter int FOSC = 50000000
) (
    input  logic osc,
    input  logic rst_n,
    input  br    baud,
    output logic tick16
);

    localparam int D0 = FOSC / (OVS * br2hz(BR_9600));
    localparam int D1 = FOSC / (OVS * br2hz(BR_19200));
    localparam int D2 = FOSC / (OVS * br2hz(BR_57600));
    localparam int D3 = FOSC / (OVS * br2hz(BR_115200));
    localparam int CW = $clog2(D0 + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] div;
    br             baud_q;

    always_comb begin
        div = CW'(D3);
        case (baud)
            BR_9600:   div = CW'(D0);
            BR_19200:  div = CW'(D1);
            BR_57600:  div = CW'(D2);
            BR_115200: div = CW'(D3);
            default:   div = CW'(D3);
        endcase
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            tick16 <= 1'b0;
            baud_q <= BR_9600;
        end else begin
            baud_q <= baud;
            tick16 <= 1'b0;
            if (baud != baud_q) begin
                cnt <= '0;
            end else if (cnt == div - CW'(1)) begin
                cnt    <= '0;
                tick16 <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_frame.sv
// Full-duplex burst UART: sends and receives bursts of SZ words of DW bits with
// optional parity, 1/2 stop bits and 16x oversampled, start-validated receive.
module uart_frame
    import uart_frame_pkg::*;
#(
    parameter int SZ   = 4,
    parameter int DW   = 8,
    parameter int FOSC = 50000000
) (
    input  logic         osc,
    input  logic         rst_n,
    uart_frame_if.slave  bus,
    output logic         tx,
    input  logic         rx
);

    localparam int IW = (SZ > 1) ? $clog2(SZ) : 1;
    localparam int BW = $clog2(DW);
    localparam logic [IW-1:0] LAST  = IW'(SZ - 1);
    localparam logic [BW-1:0] BLAST = BW'(DW - 1);

    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP, T_NEXT} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP1, R_STOP2} rx_state_t;

    logic tick16;

    uart_baud_gen #(.FOSC(FOSC)) u_baud (
        .osc    (osc),
        .rst_n  (rst_n),
        .baud   (bus.baud),
        .tick16 (tick16)
    );

    tx_state_t             ts, ts_n;
    logic [3:0]            tcnt;
    logic [BW-1:0]         tbit;
    logic [IW-1:0]         tidx;
    logic [SZ-1:0][DW-1:0] tbuf;
    par_t                  tpar;
    logic                  tstop2, tsec;
    logic                  tbit_done, tpar_bit;

    assign tbit_done = tick16 && (tcnt == 4'd15);
    assign tpar_bit  = (^tbuf[tidx]) ^ (tpar == PAR_ODD);

    always_comb begin
        ts_n        = ts;
        tx          = 1'b1;
        bus.tx_busy = 1'b1;
        case (ts)
            T_IDLE: begin
                bus.tx_busy = 1'b0;
                if (bus.en_tx) ts_n = T_START;
            end
            T_START: begin
                tx = 1'b0;
                if (tbit_done) ts_n = T_DATA;
            end
            T_DATA: begin
                tx = tbuf[tidx][tbit];
                if (tbit_done && tbit == BLAST) ts_n = (tpar == PAR_NONE) ? T_STOP : T_PARITY;
            end
            T_PARITY: begin
                tx = tpar_bit;
                if (tbit_done) ts_n = T_STOP;
            end
            T_STOP: begin
                if (tbit_done && (!tstop2 || tsec)) ts_n = T_NEXT;
            end
            T_NEXT: begin
                // Busy drops in this cycle on the last word, not one later.
                if (tidx == LAST) begin
                    ts_n        = T_IDLE;
                    bus.tx_busy = 1'b0;
                end else begin
                    ts_n = T_START;
                end
            end
            default: ts_n = T_IDLE;
        endcase
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            ts     <= T_IDLE;
            tcnt   <= '0;
            tbit   <= '0;
            tidx   <= '0;
            tpar   <= PAR_NONE;
            tstop2 <= 1'b0;
            tsec   <= 1'b0;
        end else begin
            ts <= ts_n;
            if (ts == T_IDLE || ts == T_NEXT) tcnt <= '0;
            else if (tick16)                  tcnt <= tcnt + 4'd1;
            if (ts == T_IDLE && bus.en_tx) begin
                tpar   <= bus.par;
                tstop2 <= bus.stop2;
                tidx   <= '0;
            end
            if (ts == T_START) begin
                tbit <= '0;
                tsec <= 1'b0;
            end
            if (ts == T_DATA && tbit_done)      tbit <= tbit + BW'(1);
            if (ts == T_STOP && tbit_done)      tsec <= 1'b1;
            if (ts == T_NEXT && tidx != LAST)   tidx <= tidx + IW'(1);
        end
    end

    always_ff @(posedge osc) begin
        if (ts == T_IDLE && bus.en_tx) tbuf <= bus.tx_data;
    end

    rx_state_t     rstate, rstate_n;
    logic          rs1, rs2, rprev;
    logic [3:0]    rcnt;
    logic [BW-1:0] rbit;
    logic [IW-1:0] ridx;
    logic [DW-1:0] rsh;
    par_t          rpar;
    logic          rstop2;
    logic          fall, rval, rmid, first_val, word_done, fe_set, pe_set;

    assign fall = rprev & ~rs2;
    // Validation on the 9th tick guarantees >= 8 full tick periods of low line.
    assign rval      = tick16 && (rcnt == 4'd8);
    assign rmid      = tick16 && (rcnt == 4'd15);
    assign first_val = (rstate == R_START) && rval && !rs2 && (ridx == '0);
    assign word_done = rmid && ((rstate == R_STOP1 && !rstop2) || rstate == R_STOP2);
    assign fe_set    = rmid && (rstate == R_STOP1 || rstate == R_STOP2) && !rs2;
    assign pe_set    = rmid && (rstate == R_PARITY) && (rs2 != ((^rsh) ^ (rpar == PAR_ODD)));

    always_comb begin
        rstate_n = rstate;
        case (rstate)
            R_IDLE:   if (fall) rstate_n = R_START;
            R_START:  if (rval) rstate_n = rs2 ? R_IDLE : R_DATA;
            R_DATA:   if (rmid && rbit == BLAST) rstate_n = (rpar == PAR_NONE) ? R_STOP1 : R_PARITY;
            R_PARITY: if (rmid) rstate_n = R_STOP1;
            R_STOP1:  if (rmid) rstate_n = rstop2 ? R_STOP2 : (fall ? R_START : R_IDLE);
            R_STOP2:  if (rmid) rstate_n = fall ? R_START : R_IDLE;
            default:  rstate_n = R_IDLE;
        endcase
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            rs1           <= 1'b1;
            rs2           <= 1'b1;
            rprev         <= 1'b1;
            rstate        <= R_IDLE;
            rcnt          <= '0;
            rbit          <= '0;
            ridx          <= '0;
            rpar          <= PAR_NONE;
            rstop2        <= 1'b0;
            bus.rx_full   <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.par_err   <= 1'b0;
            bus.rx_data   <= '0;
        end else begin
            rs1    <= rx;
            rs2    <= rs1;
            rprev  <= rs2;
            rstate <= rstate_n;
            if (rstate != R_START && rstate_n == R_START) rcnt <= '0;
            else if (rstate == R_START && rval)           rcnt <= '0;
            else if (tick16)                              rcnt <= rcnt + 4'd1;
            if (rstate == R_START)         rbit <= '0;
            if (rstate == R_DATA && rmid)  rbit <= rbit + BW'(1);
            // Burst configuration and sticky status restart with the first word.
            if (first_val) begin
                rpar        <= bus.par;
                rstop2      <= bus.stop2;
                bus.rx_full <= 1'b0;
            end
            bus.frame_err <= (first_val ? 1'b0 : bus.frame_err) | fe_set;
            bus.par_err   <= (first_val ? 1'b0 : bus.par_err) | pe_set;
            if (word_done) begin
                bus.rx_data[ridx] <= rsh;
                if (ridx == LAST) begin
                    ridx        <= '0;
                    bus.rx_full <= 1'b1;
                end else begin
                    ridx <= ridx + IW'(1);
                end
            end
        end
    end

    always_ff @(posedge osc) begin
        if (rstate == R_DATA && rmid) rsh <= {rs2, rsh[DW-1:1]};
    end

endmodule
